// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor : direct-mapped 2-bit counter table + BTB, trained from execute
// Optional BP_STATS_EN adds branch / mispredict counters.  Rev 1.0
// ============================================================================
`default_nettype none

module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic        bp_flush
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit;

  // Only the index and tag fields of upd_pc matter; the rest is intentionally dropped.
  logic unused_ok;
  assign unused_ok = ^{upd_pc, upd_pred_taken};

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    ctr_d    = ctr_q;
    target_d = target_q;
    if (bp_flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        ctr_d[upd_idx]    = 2'b10;
        target_d[upd_idx] = upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        ctr_q[i]    <= 2'b01;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      ctr_q    <= ctr_d;
      target_q <= target_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // Counted even when a flush drops the update.
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (upd_valid) begin
      if (stat_branches_q != 32'hFFFF_FFFF) stat_branches_d = stat_branches_q + 32'd1;
      if ((upd_pred_taken != upd_taken) && (stat_mispred_q != 32'hFFFF_FFFF))
        stat_mispred_d = stat_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// tb_branch_predictor : directed self-checking bench for branch_predictor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        bp_flush;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .bp_flush       (bp_flush)
`ifdef BP_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_t, input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    check({tag, ".target"}, pred_target, exp_tgt);
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic taken,
                        input logic [31:0] tgt, input logic pt, input logic flush);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_pred_taken = pt;
    bp_flush       = flush;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    bp_flush  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; if_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; bp_flush = 1'b0;
    #2;
    look("rst_100", 32'h100, 1'b0, 32'h104);
    look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    look("idle_100", 32'h100, 1'b0, 32'h104);

    // Same-cycle lookup sees pre-update state.
    if_pc = 32'h100; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'h80; upd_pred_taken = 1'b0;
    #1;
    check("hazard_same", {31'd0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    look("hazard_next", 32'h100, 1'b1, 32'h80);

    do_upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
    look("nt1_ctr01", 32'h100, 1'b0, 32'h104);
    do_upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    look("nt2_ctr00", 32'h100, 1'b0, 32'h104);
    do_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    look("t1_ctr01", 32'h100, 1'b0, 32'h104);
    do_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    look("t2_ctr10", 32'h100, 1'b1, 32'h80);
    do_upd(32'h100, 1'b1, 32'h80, 1'b1, 1'b0);
    look("t3_ctr11", 32'h100, 1'b1, 32'h80);
    do_upd(32'h100, 1'b1, 32'h88, 1'b1, 1'b0);
    look("t4_sat11_tgt", 32'h100, 1'b1, 32'h88);
    do_upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
    look("sat_then_nt", 32'h100, 1'b1, 32'h88);

    look("alias_miss", 32'h200, 1'b0, 32'h204);
    do_upd(32'h200, 1'b0, 32'h44, 1'b0, 1'b0);
    look("miss_nt_nochg", 32'h100, 1'b1, 32'h88);
    do_upd(32'h200, 1'b1, 32'h40, 1'b0, 1'b0);
    look("alias_alloc", 32'h200, 1'b1, 32'h40);
    look("alias_evict", 32'h100, 1'b0, 32'h104);

    do_upd(32'h4, 1'b1, 32'h500, 1'b0, 1'b0);
    look("idx1_hit", 32'h4, 1'b1, 32'h500);
    look("idx1_lowbits", 32'h6, 1'b1, 32'h500);
    look("idx1_highbits", 32'h1_0004, 1'b1, 32'h500);
    look("idx0_tag0", 32'h0, 1'b0, 32'h4);

    do_upd(32'h300, 1'b1, 32'h700, 1'b0, 1'b1);
    look("flush_300", 32'h300, 1'b0, 32'h304);
    look("flush_200", 32'h200, 1'b0, 32'h204);
    look("flush_100", 32'h100, 1'b0, 32'h104);
    look("flush_4", 32'h4, 1'b0, 32'h8);

    do_upd(32'h200, 1'b1, 32'h40, 1'b0, 1'b0);
    look("retrain", 32'h200, 1'b1, 32'h40);
    rst_n = 1'b0;
    look("async_rst", 32'h200, 1'b0, 32'h204);
    rst_n = 1'b1;
    look("post_rst", 32'h200, 1'b0, 32'h204);

`ifdef BP_STATS_EN
    check("stat_br_rst", stat_branches, 32'd0);
    do_upd(32'h800, 1'b1, 32'h900, 1'b1, 1'b0);
    do_upd(32'h800, 1'b1, 32'h900, 1'b0, 1'b0);
    do_upd(32'h800, 1'b0, 32'h900, 1'b0, 1'b0);
    do_upd(32'h800, 1'b0, 32'h900, 1'b1, 1'b0);
    do_upd(32'h800, 1'b1, 32'h900, 1'b1, 1'b0);
    check("stat_br", stat_branches, 32'd5);
    check("stat_mis", stat_mispred, 32'd2);
    bp_flush = 1'b1;
    @(posedge clk); #1;
    bp_flush = 1'b0;
    check("stat_br_flush", stat_branches, 32'd5);
    check("stat_mis_flush", stat_mispred, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
